mc_sequencer: RTL and testbench

Multi-cycle control sequencer for the 32-bit, 4-bit-opcode core. It owns the single shared memory port and steps every instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK. It drives the enables and selects for the PC, instruction register, ALU, register file and memory. Register-field extraction stays in the decoder; this block consumes only the opcode, function field, ALU zero flag and memory acknowledge.

---
 rtl/mc_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_mc_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mc_sequencer.sv
// mc_sequencer: multi-cycle control sequencer for the 32-bit, 4-bit-opcode core.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB over one shared
// memory port and drives the datapath enables and selects from the state.
module mc_sequencer #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       opcode_i,
  input  logic [3:0]       funct_i,
  input  logic             alu_zero_i,
  input  logic             mem_ack_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic             mem_addr_sel_o,
  output logic             ir_en_o,
  output logic             pc_en_o,
  output logic             pc_src_o,
  output logic [1:0]       alu_op_o,
  output logic             alu_src_imm_o,
  output logic             rf_we_o,
  output logic             wb_sel_mem_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] instr_count_o
);

  localparam int unsigned OP_W   = 4;
  localparam int unsigned ALUOP_W = 2;

  localparam logic [OP_W-1:0] OP_NOP = OP_W'(0);
  localparam logic [OP_W-1:0] OP_ALU = OP_W'(1);
  localparam logic [OP_W-1:0] OP_LW  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SW  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_BEQ = OP_W'(4);

  localparam logic [OP_W-1:0] FN_ADD = OP_W'(0);
  localparam logic [OP_W-1:0] FN_AND = OP_W'(1);

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(2);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             retire;
  logic             alu_legal;

  assign alu_legal = (opcode_i == OP_ALU) && ((funct_i == FN_ADD) || (funct_i == FN_AND));

  // State register; reset parks the sequencer at FETCH
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and retire decode
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        if (mem_ack_i) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (opcode_i == OP_NOP) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (alu_legal || (opcode_i == OP_LW) || (opcode_i == OP_SW) ||
                     (opcode_i == OP_BEQ)) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_HALT;
        end
      end
      S_EXEC: begin
        if (opcode_i == OP_ALU) begin
          state_d = S_WB;
        end else if ((opcode_i == OP_LW) || (opcode_i == OP_SW)) begin
          state_d = S_MEM;
        end else begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        if (mem_ack_i) begin
          if (opcode_i == OP_SW) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Sticky halt flag and retired-instruction counter
  always_comb begin
    halted_d = halted_q | (state_d == S_HALT);
    count_d  = retire ? (count_q + CNT_W'(1)) : count_q;
  end

  // Status registers; cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      halted_q <= 1'b0;
      count_q  <= '0;
    end else begin
      halted_q <= halted_d;
      count_q  <= count_d;
    end
  end

  // Strobe/select decode from state; reset forces every output low immediately
  always_comb begin
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    mem_addr_sel_o = 1'b0;
    ir_en_o        = 1'b0;
    pc_en_o        = 1'b0;
    pc_src_o       = 1'b0;
    alu_op_o       = ALU_ADD;
    alu_src_imm_o  = 1'b0;
    rf_we_o        = 1'b0;
    wb_sel_mem_o   = 1'b0;
    halted_o       = 1'b0;
    instr_count_o  = '0;
    if (!rst) begin
      halted_o      = halted_q;
      instr_count_o = count_q;
      unique case (state_q)
        S_FETCH: begin
          mem_req_o = 1'b1;
          ir_en_o   = mem_ack_i;
          pc_en_o   = mem_ack_i;
        end
        S_EXEC: begin
          if (opcode_i == OP_ALU) begin
            alu_op_o = (funct_i == FN_AND) ? ALU_AND : ALU_ADD;
          end else if ((opcode_i == OP_LW) || (opcode_i == OP_SW)) begin
            alu_src_imm_o = 1'b1;
          end else if (opcode_i == OP_BEQ) begin
            alu_op_o = ALU_SUB;
            pc_en_o  = alu_zero_i;
            pc_src_o = alu_zero_i;
          end
        end
        S_MEM: begin
          mem_req_o      = 1'b1;
          mem_addr_sel_o = 1'b1;
          mem_we_o       = (opcode_i == OP_SW);
        end
        S_WB: begin
          rf_we_o      = 1'b1;
          wb_sel_mem_o = (opcode_i == OP_LW);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mc_sequencer.sv
// tb_mc_sequencer: directed vector table, hand-written corner sequences and
// randomized instruction streams checked against a per-instruction model.
module tb_mc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  opcode_i;
  logic [3:0]  funct_i;
  logic        alu_zero_i;
  logic        mem_ack_i;
  logic        mem_req_o, mem_we_o, mem_addr_sel_o, ir_en_o, pc_en_o, pc_src_o;
  logic [1:0]  alu_op_o;
  logic        alu_src_imm_o, rf_we_o, wb_sel_mem_o, halted_o;
  logic [31:0] instr_count_o;

  mc_sequencer #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode_i(opcode_i), .funct_i(funct_i),
    .alu_zero_i(alu_zero_i), .mem_ack_i(mem_ack_i), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_addr_sel_o(mem_addr_sel_o), .ir_en_o(ir_en_o),
    .pc_en_o(pc_en_o), .pc_src_o(pc_src_o), .alu_op_o(alu_op_o),
    .alu_src_imm_o(alu_src_imm_o), .rf_we_o(rf_we_o), .wb_sel_mem_o(wb_sel_mem_o),
    .halted_o(halted_o), .instr_count_o(instr_count_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       req;
    logic       we;
    logic       sel;
    logic       ir;
    logic       pc;
    logic       src;
    logic [1:0] aop;
    logic       imm;
    logic       rf;
    logic       wbm;
    logic       hlt;
  } outs_t;

  typedef struct {
    logic  ack;
    outs_t exp;
  } cyc_t;

  typedef struct {
    logic [3:0] op;
    logic [3:0] fn;
    logic       z;
    int         dw;
    int         exp_cyc;
    logic       exp_rf;
    logic       exp_wbm;
    logic       exp_taken;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model_cnt = 32'd0;
  cyc_t        sched[$];

  function automatic outs_t mk(logic req, logic we, logic sel, logic ir, logic pc,
                               logic src, logic [1:0] aop, logic imm, logic rf,
                               logic wbm, logic hlt);
    outs_t o;
    o.req = req; o.we = we; o.sel = sel; o.ir = ir; o.pc = pc; o.src = src;
    o.aop = aop; o.imm = imm; o.rf = rf; o.wbm = wbm; o.hlt = hlt;
    return o;
  endfunction

  function automatic outs_t sample();
    return mk(mem_req_o, mem_we_o, mem_addr_sel_o, ir_en_o, pc_en_o, pc_src_o,
              alu_op_o, alu_src_imm_o, rf_we_o, wb_sel_mem_o, halted_o);
  endfunction

  task automatic chk_outs(input string nm, input outs_t exp);
    outs_t a;
    a = sample();
    n_checks++;
    if (a !== exp) begin
      n_fail++;
      $display("FAIL %s: outputs got %03h expected %03h (t=%0t)", nm, a, exp, $time);
    end
  endtask

  task automatic chk_num(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam outs_t ZERO = '0;

  // Transaction-level expectation for one instruction, following the phase list
  task automatic build(input logic [3:0] op, input logic [3:0] fn, input logic z,
                       input int fw, input int dw);
    sched.delete();
    for (int i = 0; i < fw; i++) sched.push_back('{1'b0, mk(1,0,0,0,0,0,2'b00,0,0,0,0)});
    sched.push_back('{1'b1, mk(1,0,0,1,1,0,2'b00,0,0,0,0)});
    sched.push_back('{1'($urandom_range(0, 1)), ZERO});
    if (op == 4'd0) return;
    case (op)
      4'd1: sched.push_back('{1'($urandom_range(0, 1)),
                              mk(0,0,0,0,0,0,(fn == 4'd1) ? 2'b01 : 2'b00,0,0,0,0)});
      4'd2, 4'd3: sched.push_back('{1'($urandom_range(0, 1)), mk(0,0,0,0,0,0,2'b00,1,0,0,0)});
      default: sched.push_back('{1'($urandom_range(0, 1)), mk(0,0,0,0,z,z,2'b10,0,0,0,0)});
    endcase
    if (op == 4'd2 || op == 4'd3) begin
      for (int i = 0; i < dw; i++)
        sched.push_back('{1'b0, mk(1,(op == 4'd3),1,0,0,0,2'b00,0,0,0,0)});
      sched.push_back('{1'b1, mk(1,(op == 4'd3),1,0,0,0,2'b00,0,0,0,0)});
    end
    if (op == 4'd1 || op == 4'd2)
      sched.push_back('{1'($urandom_range(0, 1)), mk(0,0,0,0,0,0,2'b00,0,1,(op == 4'd2),0)});
  endtask

  // Reactive memory: fetch acked at once, data acked after dw wait cycles
  task automatic run_vec(input vec_t v, input string nm);
    int   cycles = 0;
    int   dwait = 0;
    logic seen_rf = 1'b0, seen_wbm = 1'b0, seen_taken = 1'b0;
    opcode_i = v.op; funct_i = v.fn; alu_zero_i = v.z;
    while (instr_count_o == model_cnt && cycles < 30) begin
      mem_ack_i = 1'b0;
      #1;
      if (mem_req_o && !mem_addr_sel_o) mem_ack_i = 1'b1;
      else if (mem_req_o && mem_addr_sel_o) begin
        if (dwait < v.dw) dwait++;
        else mem_ack_i = 1'b1;
      end
      #1;
      seen_rf    |= rf_we_o;
      seen_wbm   |= wb_sel_mem_o;
      seen_taken |= pc_en_o & pc_src_o;
      tick();
      cycles++;
    end
    model_cnt++;
    chk_num({nm, "_cycles"}, 32'(cycles), 32'(v.exp_cyc));
    chk_num({nm, "_count"}, instr_count_o, model_cnt);
    chk_num({nm, "_flags"}, {29'd0, seen_rf, seen_wbm, seen_taken},
            {29'd0, v.exp_rf, v.exp_wbm, v.exp_taken});
  endtask

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{4'd0, 4'd0, 1'b0, 0, 2, 1'b0, 1'b0, 1'b0};  // NOP
    vecs[1]  = '{4'd0, 4'd0, 1'b0, 0, 2, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{4'd0, 4'd0, 1'b0, 0, 2, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{4'd1, 4'd0, 1'b0, 0, 4, 1'b1, 1'b0, 1'b0};  // ADD
    vecs[4]  = '{4'd1, 4'd1, 1'b1, 0, 4, 1'b1, 1'b0, 1'b0};  // AND
    vecs[5]  = '{4'd2, 4'd0, 1'b0, 0, 5, 1'b1, 1'b1, 1'b0};  // LW
    vecs[6]  = '{4'd2, 4'd0, 1'b0, 3, 8, 1'b1, 1'b1, 1'b0};  // LW, 3 waits
    vecs[7]  = '{4'd3, 4'd0, 1'b0, 0, 4, 1'b0, 1'b0, 1'b0};  // SW
    vecs[8]  = '{4'd3, 4'd0, 1'b0, 2, 6, 1'b0, 1'b0, 1'b0};  // SW, 2 waits
    vecs[9]  = '{4'd4, 4'd0, 1'b1, 0, 3, 1'b0, 1'b0, 1'b1};  // BEQ taken
    vecs[10] = '{4'd4, 4'd0, 1'b0, 0, 3, 1'b0, 1'b0, 1'b0};  // BEQ not taken

    rst = 1'b1; opcode_i = 4'd0; funct_i = 4'd0; alu_zero_i = 1'b0; mem_ack_i = 1'b1;
    repeat (3) tick();
    #1;
    chk_outs("reset_outs", ZERO);
    chk_num("reset_count", instr_count_o, 32'd0);
    tick();
    rst = 1'b0; mem_ack_i = 1'b0;
    #1;
    chk_outs("first_fetch", mk(1,0,0,0,0,0,2'b00,0,0,0,0));

    for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Randomized instruction stream against the phase model
    for (int n = 0; n < 300; n++) begin
      logic [3:0] op, fn;
      logic       z;
      op = 4'($urandom_range(0, 4));
      fn = 4'($urandom_range(0, 1));
      z  = 1'($urandom_range(0, 1));
      build(op, fn, z, $urandom_range(0, 2), $urandom_range(0, 3));
      opcode_i = op; funct_i = fn; alu_zero_i = z;
      foreach (sched[k]) begin
        mem_ack_i = sched[k].ack;
        #1;
        chk_outs($sformatf("rand%0d_op%0d_c%0d", n, op, k), sched[k].exp);
        chk_num($sformatf("rand%0d_cnt_c%0d", n, k), instr_count_o, model_cnt);
        tick();
      end
      model_cnt++;
    end

    // Reset during a SW data wait abandons the request at once
    opcode_i = 4'd3; funct_i = 4'd0; alu_zero_i = 1'b0; mem_ack_i = 1'b1;
    #1; tick();
    mem_ack_i = 1'b0;
    #1; chk_outs("sw_decode", ZERO); tick();
    chk_outs("sw_exec", mk(0,0,0,0,0,0,2'b00,1,0,0,0)); tick();
    chk_outs("sw_mem_wait", mk(1,1,1,0,0,0,2'b00,0,0,0,0)); tick();
    chk_outs("sw_mem_wait2", mk(1,1,1,0,0,0,2'b00,0,0,0,0));
    rst = 1'b1;
    #1; chk_outs("sw_rst_drop", ZERO); tick();
    rst = 1'b0; model_cnt = 32'd0;
    #1;
    chk_outs("sw_rst_fetch", mk(1,0,0,0,0,0,2'b00,0,0,0,0));
    chk_num("sw_rst_count", instr_count_o, 32'd0);

    // Illegal opcode halts until reset
    opcode_i = 4'd9; mem_ack_i = 1'b1;
    #1; chk_outs("halt_fetch", mk(1,0,0,1,1,0,2'b00,0,0,0,0)); tick();
    mem_ack_i = 1'b0;
    #1; chk_outs("halt_decode", ZERO); tick();
    for (int i = 0; i < 6; i++) begin
      mem_ack_i = 1'(i % 2);
      #1;
      chk_outs($sformatf("halt_state%0d", i), mk(0,0,0,0,0,0,2'b00,0,0,0,1));
      chk_num($sformatf("halt_count%0d", i), instr_count_o, model_cnt);
      tick();
    end
    rst = 1'b1;
    #1; chk_outs("halt_rst", ZERO); tick();
    rst = 1'b0; mem_ack_i = 1'b0;
    #1;
    chk_outs("halt_exit_fetch", mk(1,0,0,0,0,0,2'b00,0,0,0,0));
    chk_num("halt_exit_count", instr_count_o, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
